// File: rtl/trace_capture_buffer_pkg.sv
// Shared state encoding, depth helpers and window-length macro for the trace capture buffer.
`ifndef TCB_WIN_LEN
`define TCB_WIN_LEN(pre, post) ((pre) + (post) + 1)
`endif

package trace_capture_buffer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILL      = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  localparam int DEPTH_LOG2_DEF = 10;
  localparam int DEPTH          = 1 << DEPTH_LOG2_DEF;

  function automatic int depth_of(input int log2);
    return 1 << log2;
  endfunction

endpackage

// File: rtl/trace_capture_ram.sv
// Simple dual-port sample store: one write port, one registered read port, array not reset.
module trace_capture_ram
  import trace_capture_buffer_pkg::*;
#(
  parameter int W  = 256,
  parameter int AW = 10
) (
  input  logic          i_clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_data
);

  localparam int N_WORDS = depth_of(AW);

  logic [W-1:0] r_mem [N_WORDS];
  logic [W-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/trace_capture_buffer.sv
// Pre/post-trigger trace recorder: circular capture into block RAM, indexed window readout.
module trace_capture_buffer
  import trace_capture_buffer_pkg::*;
#(
  parameter int PROBE_W    = 256,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int PRE_TRIG   = 64,
  parameter int POST_TRIG  = 512
) (
  input  logic                  in_clk,
  input  logic                  in_reset,
  input  logic                  arm,
  input  logic                  trig_in,
  output logic                  trig_in_ack,
  input  logic [PROBE_W-1:0]    probe0,
  output logic                  busy,
  output logic                  done,
  output logic [DEPTH_LOG2-1:0] trig_addr,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [PROBE_W-1:0]    rd_data
);

  localparam int N_DEPTH = depth_of(DEPTH_LOG2);
  localparam int WIN_LEN = `TCB_WIN_LEN(PRE_TRIG, POST_TRIG);
  localparam int CW      = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]         PRE_LAST  = CW'(PRE_TRIG - 1);
  localparam logic [CW-1:0]         POST_LEN  = CW'(POST_TRIG);
  localparam logic [CW-1:0]         WIN_LEN_C = CW'(WIN_LEN);
  localparam logic [DEPTH_LOG2-1:0] PRE_OFS   = DEPTH_LOG2'(PRE_TRIG);
  // Zero-length pre/post phases skip their state entirely.
  localparam state_t ST_START      = (PRE_TRIG == 0) ? ST_WAIT_TRIG : ST_FILL;
  localparam state_t ST_AFTER_TRIG = (POST_TRIG == 0) ? ST_DONE : ST_POST;

  if (WIN_LEN > N_DEPTH) begin : g_bad_window
    $error("trace_capture_buffer: PRE_TRIG + POST_TRIG + 1 exceeds buffer depth");
  end

  state_t                r_state, w_state_next;
  logic [DEPTH_LOG2-1:0] r_wr_ptr, w_wr_ptr_next;
  logic [CW-1:0]         r_cnt, w_cnt_next;
  logic [CW-1:0]         r_post_cnt, w_post_cnt_next;
  logic [DEPTH_LOG2-1:0] r_trig_addr, w_trig_addr_next;
  logic                  r_ack, w_ack_next;
  logic                  r_trig_prev;
  logic                  r_rd_valid;
  logic                  r_rd_ok;
  logic                  w_wr_en;
  logic                  w_trig_edge;
  logic [DEPTH_LOG2-1:0] w_rd_addr;
  logic [PROBE_W-1:0]    w_rd_q;

  assign w_trig_edge = trig_in & ~r_trig_prev;

  always_comb begin
    w_state_next     = r_state;
    w_wr_ptr_next    = r_wr_ptr;
    w_cnt_next       = r_cnt;
    w_post_cnt_next  = r_post_cnt;
    w_trig_addr_next = r_trig_addr;
    w_ack_next       = 1'b0;
    w_wr_en          = 1'b0;
    if (arm) begin
      // arm restarts from any state and outranks a coincident trigger edge
      w_state_next  = ST_START;
      w_wr_ptr_next = '0;
      w_cnt_next    = '0;
    end else begin
      case (r_state)
        ST_FILL: begin
          w_wr_en       = 1'b1;
          w_wr_ptr_next = r_wr_ptr + 1'b1;
          w_cnt_next    = r_cnt + 1'b1;
          if (r_cnt == PRE_LAST) w_state_next = ST_WAIT_TRIG;
        end
        ST_WAIT_TRIG: begin
          w_wr_en       = 1'b1;
          w_wr_ptr_next = r_wr_ptr + 1'b1;
          if (w_trig_edge) begin
            w_trig_addr_next = r_wr_ptr;
            w_ack_next       = 1'b1;
            w_post_cnt_next  = POST_LEN;
            w_state_next     = ST_AFTER_TRIG;
          end
        end
        ST_POST: begin
          w_wr_en         = 1'b1;
          w_wr_ptr_next   = r_wr_ptr + 1'b1;
          w_post_cnt_next = r_post_cnt - 1'b1;
          if (r_post_cnt == CW'(1)) w_state_next = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_cnt       <= '0;
      r_post_cnt  <= '0;
      r_trig_addr <= '0;
      r_ack       <= 1'b0;
      r_trig_prev <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_ok     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_wr_ptr    <= w_wr_ptr_next;
      r_cnt       <= w_cnt_next;
      r_post_cnt  <= w_post_cnt_next;
      r_trig_addr <= w_trig_addr_next;
      r_ack       <= w_ack_next;
      r_trig_prev <= trig_in;
      r_rd_valid  <= rd_en;
      r_rd_ok     <= rd_en & (r_state == ST_DONE) & ({1'b0, rd_idx} < WIN_LEN_C);
    end
  end

  assign w_rd_addr = r_trig_addr - PRE_OFS + rd_idx;

  trace_capture_ram #(
    .W  (PROBE_W),
    .AW (DEPTH_LOG2)
  ) u_ram (
    .i_clk     (in_clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (probe0),
    .i_rd_en   (rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_q)
  );

  assign busy        = (r_state == ST_FILL) | (r_state == ST_WAIT_TRIG) | (r_state == ST_POST);
  assign done        = (r_state == ST_DONE);
  assign trig_in_ack = r_ack;
  assign trig_addr   = r_trig_addr;
  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_ok ? w_rd_q : '0;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed-plus-random bench for trace_capture_buffer with a cycle-history reference model.
module tb_trace_capture_buffer;

  localparam int PW    = 256;
  localparam int DL    = 4;
  localparam int PRE   = 4;
  localparam int POST  = 8;
  localparam int DEPTH = 16;
  localparam int HN    = 2048;

  logic          in_clk   = 1'b0;
  logic          in_reset = 1'b1;
  logic          arm      = 1'b0;
  logic          trig_in  = 1'b0;
  logic          rd_en    = 1'b0;
  logic [DL-1:0] rd_idx   = '0;
  logic [PW-1:0] probe0   = '0;
  logic          trig_in_ack, busy, done, rd_valid;
  logic [DL-1:0] trig_addr;
  logic [PW-1:0] rd_data;

  trace_capture_buffer #(
    .PROBE_W    (PW),
    .DEPTH_LOG2 (DL),
    .PRE_TRIG   (PRE),
    .POST_TRIG  (POST)
  ) dut (
    .in_clk      (in_clk),
    .in_reset    (in_reset),
    .arm         (arm),
    .trig_in     (trig_in),
    .trig_in_ack (trig_in_ack),
    .probe0      (probe0),
    .busy        (busy),
    .done        (done),
    .trig_addr   (trig_addr),
    .rd_en       (rd_en),
    .rd_idx      (rd_idx),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data)
  );

  always #5 in_clk = ~in_clk;

  int n_assert = 0;
  int n_fail   = 0;
  int c        = 0;
  logic [PW-1:0] hist [HN];

  // Model: a capture is (arm cycle, trigger cycle); the window is the probe history around the trigger.
  bit            m_active, m_done, m_prev, m_ack, m_valid;
  int            m_arm_cyc, m_trig_cyc;
  logic [DL-1:0] m_taddr;
  logic [PW-1:0] m_rdata;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0; m_prev = 0; m_ack = 0; m_valid = 0;
    m_arm_cyc = 0; m_trig_cyc = -1; m_taddr = '0; m_rdata = '0;
  endtask

  task automatic step(input bit a, input bit t, input bit re, input int ri);
    logic [PW-1:0] pv;
    bit edge_t, was_done;
    int tc;
    arm = a; trig_in = t; rd_en = re; rd_idx = DL'(ri);
    for (int k = 0; k < PW / 32; k++) pv[32*k +: 32] = $urandom;
    pv[31:0] = c;
    probe0 = pv;
    hist[c % HN] = pv;
    was_done = m_done;
    tc = m_trig_cyc;
    edge_t = t && !m_prev;
    m_prev = t;
    m_ack = 0;
    if (a) begin
      m_active = 1; m_done = 0; m_arm_cyc = c; m_trig_cyc = -1;
    end else if (m_active && m_trig_cyc < 0) begin
      if (edge_t && (c - m_arm_cyc) > PRE) begin
        m_trig_cyc = c;
        m_ack = 1;
        m_taddr = DL'((c - m_arm_cyc - 1) % DEPTH);
      end
    end else if (m_active && (c - m_trig_cyc) == POST) begin
      m_active = 0; m_done = 1;
    end
    m_valid = re;
    m_rdata = (re && was_done && ri <= PRE + POST) ? hist[(tc - PRE + ri) % HN] : '0;
    @(posedge in_clk);
    #1;
    c++;
    chk("busy", busy, m_active);
    chk("done", done, m_done);
    chk("ack", trig_in_ack, m_ack);
    chk("trig_addr", trig_addr, m_taddr);
    chk("rd_valid", rd_valid, m_valid);
    if (m_valid) chk("rd_data", rd_data, m_rdata);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15));
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (done !== 1'b1 && k < bound) begin
      step(0, 0, 0, 0);
      k++;
    end
    chk("done_wait", done, 1'b1);
  endtask

  task automatic readout(input int tcyc);
    for (int i = 0; i < 15; i++) step(0, 0, 1, i);
    step(0, 0, 1, PRE);
    chk("trig_sample", rd_data[31:0], 32'(tcyc));
  endtask

  task automatic mid_reset();
    #2;
    in_reset = 1; arm = 0; trig_in = 0; rd_en = 0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ack", trig_in_ack, 1'b0);
    chk("rst_valid", rd_valid, 1'b0);
    chk("rst_taddr", trig_addr, '0);
    model_reset();
    @(posedge in_clk);
    #1;
    c++;
    in_reset = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tcyc;
    model_reset();
    repeat (3) @(posedge in_clk);
    #1;
    chk("init_busy", busy, 1'b0);
    chk("init_done", done, 1'b0);
    chk("init_ack", trig_in_ack, 1'b0);
    chk("init_valid", rd_valid, 1'b0);
    chk("init_data", rd_data, '0);
    chk("init_taddr", trig_addr, '0);
    in_reset = 0;
    idle(20);
    step(0, 0, 1, 0);

    // basic capture
    step(1, 0, 0, 0);
    idle(9);
    tcyc = c;
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    wait_done(30);
    readout(tcyc);

    // edge during fill ignored, later edge captured
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    idle(12);
    tcyc = c;
    step(0, 1, 0, 0);
    wait_done(30);
    readout(tcyc);

    // trigger held high across fill: no capture until a fresh rise
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int k = 0; k < 18; k++) step(0, 1, 1'($urandom_range(0, 1)), $urandom_range(0, 15));
    idle(4);
    tcyc = c;
    step(0, 1, 0, 0);
    wait_done(30);
    readout(tcyc);

    // abort during post
    step(1, 0, 0, 0);
    idle(8);
    step(0, 1, 0, 0);
    idle(3);
    step(1, 0, 0, 0);
    idle(14);
    tcyc = c;
    step(0, 1, 0, 0);
    wait_done(30);
    readout(tcyc);

    // arm and trigger edge in the same cycle
    step(1, 0, 0, 0);
    idle(8);
    step(1, 1, 0, 0);
    idle(7);
    tcyc = c;
    step(0, 1, 0, 0);
    wait_done(30);
    readout(tcyc);

    // long wait before trigger: pointer wraps several times
    step(1, 0, 0, 0);
    idle(89);
    tcyc = c;
    step(0, 1, 0, 0);
    wait_done(30);
    readout(tcyc);

    // reset in the middle of post
    step(1, 0, 0, 0);
    idle(8);
    step(0, 1, 0, 0);
    mid_reset();
    idle(3);
    step(0, 0, 1, PRE);
    chk("post_rst_data", rd_data, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/trace_capture_buffer.md
Name: trace_capture_buffer

Overview:
- In-fabric trace recorder on the consumer side of the mlacc debug interface; drop-in alternative to the vendor ILA.
- Takes the accelerator's trigger pulse and 256-bit monitored-signal bus.
- Stores a pre/post-trigger window in an on-chip circular RAM and returns a one-cycle trigger acknowledge.
- Exposes an indexed readout port so a host-side controller can drain the window after capture.

Parameters:
- PROBE_W, 256, width of monitored-signal bus and of each stored sample.
- DEPTH_LOG2, 10, log2 of buffer depth; DEPTH = 2**DEPTH_LOG2.
- PRE_TRIG, 64, samples kept before the trigger sample.
- POST_TRIG, 512, samples kept after the trigger sample.
- Constraint: PRE_TRIG + POST_TRIG + 1 <= DEPTH; check at elaboration.

Ports:
- in_clk  input  1  sole clock, all logic rising-edge.
- in_reset  input  1  asynchronous, active-high reset.
- arm  input  1  one-cycle pulse; starts (or restarts) a capture.
- trig_in  input  1  trigger from the accelerator; rising edge is significant.
- trig_in_ack  output  1  one-cycle pulse when a trigger is accepted.
- probe0  input  PROBE_W  monitored signal; sampled every cycle while recording.
- busy  output  1  high from FILL through POST.
- done  output  1  high in DONE; window is valid.
- trig_addr  output  DEPTH_LOG2  RAM address of the trigger sample.
- rd_en  input  1  read request.
- rd_idx  input  DEPTH_LOG2  window index; 0 = oldest sample, PRE_TRIG = trigger sample.
- rd_valid  output  1  high one cycle after rd_en.
- rd_data  output  PROBE_W  read sample.

Behaviour:
- Reset: state IDLE; wr_ptr, counters, trig_addr = 0; trig_in_ack, busy, done, rd_valid = 0; rd_data = 0; trig_prev = 0. RAM contents are not reset.
- Edge detect: trig_prev <= trig_in every cycle in every state. trig_edge = trig_in & ~trig_prev.
- IDLE: no writes. arm -> FILL with wr_ptr = 0 and count = 0.
- FILL:
  - Write probe0 to mem[wr_ptr], wr_ptr++ (mod DEPTH), count++.
  - After the PRE_TRIG-th write -> WAIT_TRIG.
  - trig_edge is ignored; no ack.
  - PRE_TRIG = 0: go straight to WAIT_TRIG.
- WAIT_TRIG:
  - Write every cycle, pointer wraps freely.
  - On trig_edge: the same-cycle sample is written; trig_addr <= wr_ptr; trig_in_ack = 1 the next cycle only; post counter = POST_TRIG -> POST.
- POST:
  - Write every cycle and decrement the post counter.
  - After the POST_TRIG-th write -> DONE. POST_TRIG = 0 goes directly to DONE.
  - Further trigger edges are ignored.
- DONE: no writes; done = 1. arm -> FILL (new capture, done drops).
- arm in FILL, WAIT_TRIG or POST: abort and restart FILL with the pointer reset. done stays 0.
- arm and trig_edge in the same cycle: arm wins; no ack.
- Readout:
  - rd_valid and rd_data are registered one cycle after rd_en.
  - Address = trig_addr - PRE_TRIG + rd_idx (mod DEPTH).
  - rd_idx > PRE_TRIG + POST_TRIG, or a read while done = 0: rd_data = 0, rd_valid still 1.
  - Reads do not disturb capture state.
- Reset mid-operation: immediate return to the reset state; a stale window is not readable (done = 0).
- Memory: simple dual-port, 1 write and 1 synchronous read, PROBE_W x DEPTH, inferred block RAM.

Decomposition:
- Shared package/header holds:
  - state encoding: IDLE=0, FILL=1, WAIT_TRIG=2, POST=3, DONE=4 (3 bits);
  - the DEPTH localparam;
  - the window-length macro PRE_TRIG+POST_TRIG+1.
- One sub-module, trace_capture_ram: parameterised simple dual-port RAM with registered read, no reset on the array.

Test Plan (DEPTH_LOG2=4, PRE_TRIG=4, POST_TRIG=8; probe0 = free-running cycle count c):
- Reset then idle for 20 cycles -> all outputs 0, rd_en gives rd_valid = 1 with rd_data = 0.
- Basic capture: arm sampled at c=10 (FILL writes 11..14); trig_in rises at c=20.
  - Trigger response: trig_in_ack high at c=21 only; done high from c=29.
  - Readout: rd_idx 0..12 returns 16..28, rd_idx 4 = 20, rd_idx 13 returns 0.
- Trigger timing:
  - Edge at c=12 during FILL -> no ack; a later edge at c=25 is captured with rd_idx 4 = 25.
  - trig_in held high from c=12 to 30 -> no capture; a fresh rise at c=35 is captured (rd_idx 4 = 35).
- Abort and collision:
  - arm at c=24 during POST (trigger at 20) -> done stays 0, busy stays 1; a new trigger at 40 gives rd_idx 4 = 40.
  - arm and trigger edge in the same cycle -> no ack, FILL restarts.
- Wrap: trigger long after FILL (c=100) -> window indices 0..12 return 96..108 even though the pointer wrapped several times.
- Reset asserted at c=24 mid-POST -> busy, done, trig_in_ack = 0 the same cycle; after release, state is IDLE and reads return 0.
